// File: rtl/fpu_core.sv
// rtl/fpu_core.sv - x87-style register-stack core: FLD / FST / FXCH with tag, status and control words
// Single-cycle stack management only; no arithmetic. Each execute completes on its own edge.
module fpu_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        execute,
  input  logic [7:0]  instruction,
  input  logic [2:0]  stack_index,
  input  logic [79:0] data_in,
  input  logic [31:0] int_data_in,
  input  logic [15:0] control_in,
  input  logic        control_write,
  output logic        ready,
  output logic        error,
  output logic [79:0] data_out,
  output logic [15:0] status_out
);

  localparam logic [7:0]  OP_FLD     = 8'h20;
  localparam logic [7:0]  OP_FST     = 8'h21;
  localparam logic [7:0]  OP_FXCH    = 8'h23;
  localparam logic [79:0] INDEFINITE = 80'hFFFF_C000_0000_0000_0000;
  localparam logic [15:0] CTRL_RESET = 16'h037F;

  logic [79:0] r_regs [8];
  logic [7:0]  r_tag;
  logic [2:0]  r_top;
  logic        r_ie;
  logic        r_sf;
  logic        r_c1;
  logic [15:0] r_control;
  logic        r_ready;
  logic        r_error;
  logic [79:0] r_data_out;

  logic [2:0]  w_push_idx;
  logic [2:0]  w_sti_idx;
  logic        w_push_ovf;
  logic        w_sti_empty;
  logic        w_st0_empty;
  logic        w_es;
  logic        w_unused;

  assign w_push_idx  = r_top - 3'd1;
  assign w_sti_idx   = r_top + stack_index;
  assign w_push_ovf  = r_tag[w_push_idx];
  assign w_sti_empty = ~r_tag[w_sti_idx];
  assign w_st0_empty = ~r_tag[r_top];
  // Only IE is ever raised, so ES reduces to IE gated by its mask bit.
  assign w_es        = |({5'b0, r_ie} & ~r_control[5:0]);
  assign w_unused    = ^int_data_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 8; k++) r_regs[k] <= '0;
      r_tag      <= '0;
      r_top      <= '0;
      r_ie       <= 1'b0;
      r_sf       <= 1'b0;
      r_c1       <= 1'b0;
      r_control  <= CTRL_RESET;
      r_ready    <= 1'b0;
      r_error    <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_ready <= execute;
      r_error <= 1'b0;
      if (control_write) r_control <= control_in;
      if (execute) begin
        case (instruction)
          OP_FLD: begin
            // Overflow still pushes; the stale value is overwritten.
            r_regs[w_push_idx] <= data_in;
            r_tag[w_push_idx]  <= 1'b1;
            r_top              <= w_push_idx;
            if (w_push_ovf) begin
              r_ie    <= 1'b1;
              r_sf    <= 1'b1;
              r_c1    <= 1'b1;
              r_error <= 1'b1;
            end
          end
          OP_FST: begin
            if (w_sti_empty) begin
              r_data_out <= INDEFINITE;
              r_ie       <= 1'b1;
              r_sf       <= 1'b1;
              r_c1       <= 1'b0;
              r_error    <= 1'b1;
            end else begin
              r_data_out <= r_regs[w_sti_idx];
            end
          end
          OP_FXCH: begin
            if (w_st0_empty || w_sti_empty) begin
              r_ie    <= 1'b1;
              r_sf    <= 1'b1;
              r_c1    <= 1'b0;
              r_error <= 1'b1;
            end else begin
              // Both tags are valid here, so only the values need swapping.
              r_regs[r_top]     <= r_regs[w_sti_idx];
              r_regs[w_sti_idx] <= r_regs[r_top];
            end
          end
          default: begin
            r_ie    <= 1'b1;
            r_error <= 1'b1;
          end
        endcase
      end
    end
  end

  assign ready      = r_ready;
  assign error      = r_error;
  assign data_out   = r_data_out;
  assign status_out = {w_es, 1'b0, r_top, 1'b0, r_c1, 1'b0, w_es, r_sf, 5'b0, r_ie};

endmodule

// File: tb/tb_fpu_core.sv
// tb/tb_fpu_core.sv - self-checking bench for fpu_core: directed vector table, corner sequences, random ops vs model
module tb_fpu_core;

  localparam logic [79:0] INDEF = 80'hFFFF_C000_0000_0000_0000;
  localparam logic [79:0] V1 = 80'h3FFF_8000_0000_0000_0000;
  localparam logic [79:0] V2 = 80'h4000_8000_0000_0000_0000;
  localparam logic [79:0] V3 = 80'h4000_C000_0000_0000_0000;
  localparam logic [79:0] V4 = 80'h4001_8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        execute = 1'b0;
  logic [7:0]  instruction = '0;
  logic [2:0]  stack_index = '0;
  logic [79:0] data_in = '0;
  logic [31:0] int_data_in = '0;
  logic [15:0] control_in = '0;
  logic        control_write = 1'b0;
  logic        ready;
  logic        error;
  logic [79:0] data_out;
  logic [15:0] status_out;

  fpu_core dut (
    .clk(clk), .reset(reset), .execute(execute), .instruction(instruction),
    .stack_index(stack_index), .data_in(data_in), .int_data_in(int_data_in),
    .control_in(control_in), .control_write(control_write), .ready(ready),
    .error(error), .data_out(data_out), .status_out(status_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: an 8-entry ring of values and valid flags plus sticky flags.
  logic [79:0] m_regs [8];
  bit          m_tag [8];
  int          m_top;
  bit          m_ie, m_sf, m_c1;
  logic [15:0] m_ctrl;
  logic [79:0] m_dout;
  bit          m_err;

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      m_regs[k] = '0;
      m_tag[k]  = 0;
    end
    m_top = 0; m_ie = 0; m_sf = 0; m_c1 = 0;
    m_ctrl = 16'h037F; m_dout = '0; m_err = 0;
  endtask

  function automatic logic [15:0] model_status();
    int es;
    es = (m_ie && !m_ctrl[0]) ? 1 : 0;
    return 16'(es * 32768 + m_top * 2048 + int'(m_c1) * 512 + es * 128 + int'(m_sf) * 64 + int'(m_ie));
  endfunction

  task automatic model_exec(input logic [7:0] op, input int idx, input logic [79:0] d);
    int p;
    logic [79:0] t;
    m_err = 0;
    p = (m_top + idx) % 8;
    if (op == 8'h20) begin
      p = (m_top + 7) % 8;
      if (m_tag[p]) begin m_err = 1; m_ie = 1; m_sf = 1; m_c1 = 1; end
      m_regs[p] = d; m_tag[p] = 1; m_top = p;
    end else if (op == 8'h21) begin
      if (!m_tag[p]) begin m_err = 1; m_ie = 1; m_sf = 1; m_c1 = 0; m_dout = INDEF; end
      else m_dout = m_regs[p];
    end else if (op == 8'h23) begin
      if (!m_tag[m_top] || !m_tag[p]) begin m_err = 1; m_ie = 1; m_sf = 1; m_c1 = 0; end
      else begin t = m_regs[m_top]; m_regs[m_top] = m_regs[p]; m_regs[p] = t; end
    end else begin
      m_err = 1; m_ie = 1;
    end
  endtask

  task automatic compare_model(input string tag, input bit exp_ready);
    check({tag, " ready"}, {79'b0, ready}, {79'b0, exp_ready});
    check({tag, " error"}, {79'b0, error}, {79'b0, exp_ready & m_err});
    check({tag, " data_out"}, data_out, m_dout);
    check({tag, " status"}, {64'b0, status_out}, {64'b0, model_status()});
  endtask

  task automatic do_op(input logic [7:0] op, input logic [2:0] idx, input logic [79:0] d,
                       input bit cw, input logic [15:0] ctrl);
    @(negedge clk);
    execute = 1'b1; instruction = op; stack_index = idx; data_in = d;
    control_write = cw; control_in = ctrl; int_data_in = $urandom;
    model_exec(op, int'(idx), d);
    if (cw) m_ctrl = ctrl;
    @(posedge clk); #1;
    compare_model("op", 1'b1);
  endtask

  task automatic idle(input bit cw, input logic [15:0] ctrl);
    @(negedge clk);
    execute = 1'b0; control_write = cw; control_in = ctrl;
    if (cw) m_ctrl = ctrl;
    @(posedge clk); #1;
    compare_model("idle", 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; execute = 1'b0; control_write = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [2:0]  idx;
    logic [79:0] data;
    logic        exp_err;
    logic [79:0] exp_dout;
    logic [15:0] exp_status;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [7:0] op, logic [2:0] idx, logic [79:0] d,
                              logic e, logic [79:0] dout, logic [15:0] st);
    vec_t v;
    v.op = op; v.idx = idx; v.data = d; v.exp_err = e; v.exp_dout = dout; v.exp_status = st;
    return v;
  endfunction

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();
    #1;
    check("reset status", {64'b0, status_out}, 80'h0);
    check("reset ready", {79'b0, ready}, 80'h0);
    check("reset error", {79'b0, error}, 80'h0);
    check("reset data_out", data_out, 80'h0);

    tbl.push_back(mk(8'h20, 3'd0, V1, 1'b0, '0, 16'h3800));
    tbl.push_back(mk(8'h20, 3'd0, V2, 1'b0, '0, 16'h3000));
    tbl.push_back(mk(8'h20, 3'd0, V3, 1'b0, '0, 16'h2800));
    tbl.push_back(mk(8'h20, 3'd0, V4, 1'b0, '0, 16'h2000));
    tbl.push_back(mk(8'h21, 3'd0, '0, 1'b0, V4, 16'h2000));
    tbl.push_back(mk(8'h21, 3'd1, '0, 1'b0, V3, 16'h2000));
    tbl.push_back(mk(8'h21, 3'd2, '0, 1'b0, V2, 16'h2000));
    tbl.push_back(mk(8'h21, 3'd3, '0, 1'b0, V1, 16'h2000));
    tbl.push_back(mk(8'h23, 3'd1, '0, 1'b0, '0, 16'h2000));
    tbl.push_back(mk(8'h21, 3'd0, '0, 1'b0, V3, 16'h2000));
    tbl.push_back(mk(8'h21, 3'd1, '0, 1'b0, V4, 16'h2000));
    tbl.push_back(mk(8'h23, 3'd2, '0, 1'b0, '0, 16'h2000));
    tbl.push_back(mk(8'h21, 3'd0, '0, 1'b0, V2, 16'h2000));
    tbl.push_back(mk(8'h21, 3'd2, '0, 1'b0, V3, 16'h2000));
    tbl.push_back(mk(8'h23, 3'd3, '0, 1'b0, '0, 16'h2000));
    tbl.push_back(mk(8'h21, 3'd0, '0, 1'b0, V1, 16'h2000));
    tbl.push_back(mk(8'h21, 3'd3, '0, 1'b0, V2, 16'h2000));
    tbl.push_back(mk(8'h21, 3'd5, '0, 1'b1, INDEF, 16'h2041));

    foreach (tbl[i]) begin
      do_op(tbl[i].op, tbl[i].idx, tbl[i].data, 1'b0, 16'h0);
      check($sformatf("tbl%0d error", i), {79'b0, error}, {79'b0, tbl[i].exp_err});
      check($sformatf("tbl%0d status", i), {64'b0, status_out}, {64'b0, tbl[i].exp_status});
      if (tbl[i].op == 8'h21)
        check($sformatf("tbl%0d data_out", i), data_out, tbl[i].exp_dout);
    end
    idle(1'b0, 16'h0);
    check("ready single pulse", {79'b0, ready}, 80'h0);

    // Nine pushes: the ninth lands on an occupied slot and TOP wraps to 7.
    do_reset();
    for (int k = 0; k < 9; k++) do_op(8'h20, 3'd0, 80'(k + 1), 1'b0, 16'h0);
    check("ovf error", {79'b0, error}, 80'h1);
    check("ovf status", {64'b0, status_out}, 80'h3A41);
    do_op(8'hFF, 3'd2, '0, 1'b0, 16'h0);
    check("bad op ready", {79'b0, ready}, 80'h1);
    check("bad op error", {79'b0, error}, 80'h1);
    check("bad op top", {77'b0, status_out[13:11]}, 80'd7);
    idle(1'b1, 16'h037E);
    check("unmasked ES/B", {64'b0, status_out}, 80'hBAC1);
    do_op(8'h21, 3'd0, '0, 1'b0, 16'h0);
    check("regs kept after bad op", data_out, 80'd9);

    do_reset();
    #1;
    check("reset after loads", {64'b0, status_out}, 80'h0);
    do_op(8'h21, 3'd0, '0, 1'b0, 16'h0);
    check("empty FST error", {79'b0, error}, 80'h1);
    check("empty FST data", data_out, INDEF);

    // Reset coincident with execute discards the instruction.
    do_reset();
    @(negedge clk);
    reset = 1'b1; execute = 1'b1; instruction = 8'h20; data_in = V1;
    @(posedge clk); #1;
    check("reset+exec ready", {79'b0, ready}, 80'h0);
    check("reset+exec status", {64'b0, status_out}, 80'h0);
    @(negedge clk);
    reset = 1'b0; execute = 1'b0;
    model_reset();
    idle(1'b0, 16'h0);

    for (int n = 0; n < 400; n++) begin
      int r;
      logic [7:0] op;
      r = int'($urandom_range(0, 99));
      if (r < 35) op = 8'h20;
      else if (r < 65) op = 8'h21;
      else if (r < 90) op = 8'h23;
      else op = 8'($urandom);
      if ($urandom_range(0, 49) == 0) do_reset();
      else if ($urandom_range(0, 9) == 0) idle($urandom_range(0, 1) == 1, 16'($urandom));
      else do_op(op, 3'($urandom), {16'($urandom), 32'($urandom), 32'($urandom)},
                 $urandom_range(0, 7) == 0, 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
